clock_gate_ctrl: RTL and testbench

// - Generates the enable for the clock gating cell wrapper of one compute unit.
// - Watches unit activity, gates the unit clock after a programmable idle window

---
 rtl/clock_gate_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_gate_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clock_gate_ctrl.sv
// Clock gating controller for one compute unit.
// Watches unit activity, requests sleep after an idle window, drops the gating-cell
// enable once the unit acknowledges, and restores the clock when a request or an
// override arrives. Upstream requests are held off with ready until the clock is stable.
// Optional build macro: CLOCK_GATE_CTRL_STATS_EN adds a saturating count of gated cycles.
module clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        force_on_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        unit_ready_i,
  output logic        sleep_req_o,
  input  logic        sleep_ack_i,
  output logic        cg_en_o,
  output logic        gated_o
`ifdef CLOCK_GATE_CTRL_STATS_EN
  ,
  output logic [31:0] gated_cycles_o
`endif
);

  typedef enum logic [1:0] {StRun, StSleepReq, StGated, StWake} state_e;

  localparam logic [CNT_WIDTH-1:0] IdleMax  = CNT_WIDTH'(IDLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WakeLast = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] idle_q, idle_d;
  logic [CNT_WIDTH-1:0] wake_q, wake_d;
  logic                 cg_en_q, sleep_req_q, gated_q;
  logic                 active;

  assign active = busy_i | req_valid_i | force_on_i;

  // Next-state logic for the gating FSM and its idle/wake counters.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    unique case (state_q)
      StRun: begin
        if (active) begin
          idle_d = '0;
        end else if (idle_q >= IdleMax) begin
          // Only an idle cycle can start the sleep handshake, so a pending valid blocks it.
          state_d = StSleepReq;
          idle_d  = '0;
        end else if (idle_q != CntMax) begin
          idle_d = idle_q + 1'b1;
        end
      end
      StSleepReq: begin
        // Activity beats a same-cycle acknowledge.
        if (active) begin
          state_d = StRun;
          idle_d  = '0;
        end else if (sleep_ack_i) begin
          state_d = StGated;
        end
      end
      StGated: begin
        if (req_valid_i || force_on_i) begin
          state_d = StWake;
          wake_d  = '0;
        end
      end
      StWake: begin
        if (wake_q >= WakeLast) begin
          state_d = StRun;
        end else if (wake_q != CntMax) begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State, counters and registered outputs; reset forces the unit clock on at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      idle_q      <= '0;
      wake_q      <= '0;
      cg_en_q     <= 1'b1;
      sleep_req_q <= 1'b0;
      gated_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      wake_q      <= wake_d;
      cg_en_q     <= (state_d != StGated);
      sleep_req_q <= (state_d == StSleepReq);
      gated_q     <= (state_d == StGated);
    end
  end

  assign cg_en_o     = cg_en_q;
  assign sleep_req_o = sleep_req_q;
  assign gated_o     = gated_q;
  assign req_ready_o = unit_ready_i & (state_q == StRun);

`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [31:0] gated_cycles_q;

  // Saturating count of cycles spent gated; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gated_cycles_q <= '0;
    end else if (state_q == StGated && gated_cycles_q != 32'hFFFF_FFFF) begin
      gated_cycles_q <= gated_cycles_q + 32'd1;
    end
  end

  assign gated_cycles_o = gated_cycles_q;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2).
// Per-cycle vectors carry inputs and the outputs expected during that cycle; expected
// values go into a scoreboard queue when driven and are popped at the falling edge.
module tb_clock_gate_ctrl;

  logic clk = 1'b0;
  logic rst, busy, frc, valid, ready, uready, sreq, ack, cg_en, gated;
`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [31:0] gcycles;
`endif

  always #5 clk = ~clk;

  clock_gate_ctrl #(
    .IDLE_CYCLES (16),
    .WAKE_CYCLES (2),
    .CNT_WIDTH   (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .busy_i         (busy),
    .force_on_i     (frc),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .unit_ready_i   (uready),
    .sleep_req_o    (sreq),
    .sleep_ack_i    (ack),
    .cg_en_o        (cg_en),
    .gated_o        (gated)
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    .gated_cycles_o (gcycles)
`endif
  );

  typedef struct {
    int   rep;
    logic busy, valid, frc, ack, ur;
    logic cg, sr, g, rdy;
  } vec_t;

  typedef struct {
    int   idx;
    logic cg, sr, g, rdy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int rep, input logic b, input logic v, input logic f,
                     input logic a, input logic u, input logic cg, input logic sr,
                     input logic g, input logic rdy);
    vec_t x;
    x.rep = rep; x.busy = b; x.valid = v; x.frc = f; x.ack = a; x.ur = u;
    x.cg = cg; x.sr = sr; x.g = g; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_vecs(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        busy = vecs[i].busy; valid = vecs[i].valid; frc = vecs[i].frc;
        ack = vecs[i].ack; uready = vecs[i].ur;
        e.idx = i; e.cg = vecs[i].cg; e.sr = vecs[i].sr; e.g = vecs[i].g;
        e.rdy = vecs[i].rdy;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("v%0d.%0d cg_en", e.idx, r), 32'(cg_en), 32'(e.cg));
        chk($sformatf("v%0d.%0d sleep_req", e.idx, r), 32'(sreq), 32'(e.sr));
        chk($sformatf("v%0d.%0d gated", e.idx, r), 32'(gated), 32'(e.g));
        chk($sformatf("v%0d.%0d req_ready", e.idx, r), 32'(ready), 32'(e.rdy));
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    //  rep  b  v  f  a  u   cg sr g  rdy
    add(17, 0, 0, 0, 0, 1,  1, 0, 0, 1);  // 0: idle cycles 0..16
    add(3,  0, 0, 0, 0, 1,  1, 1, 0, 0);  // 1: sleep_req from cycle 17
    add(1,  0, 0, 0, 1, 1,  1, 1, 0, 0);  // 2: ack at cycle 20
    add(2,  0, 0, 0, 0, 1,  0, 0, 1, 0);  // 3: gated from 21
    add(3,  1, 0, 0, 1, 1,  0, 0, 1, 0);  // 4: busy/ack ignored while gated
    add(1,  0, 1, 0, 0, 1,  0, 0, 1, 0);  // 5: valid at N
    add(2,  0, 1, 0, 0, 1,  1, 0, 0, 0);  // 6: wake N+1, N+2
    add(1,  0, 1, 0, 0, 1,  1, 0, 0, 1);  // 7: transfer at N+3
    add(10, 0, 0, 0, 0, 1,  1, 0, 0, 1);  // 8: idle count to 10
    add(1,  1, 0, 0, 0, 1,  1, 0, 0, 1);  // 9: busy pulse restarts window
    add(17, 0, 0, 0, 0, 1,  1, 0, 0, 1);  // 10
    add(1,  0, 0, 0, 0, 1,  1, 1, 0, 0);  // 11: sleep_req again
    add(1,  0, 1, 0, 1, 1,  1, 1, 0, 0);  // 12: valid and ack together
    add(1,  0, 1, 0, 0, 1,  1, 0, 0, 1);  // 13: activity won, transfer
    add(100,0, 0, 1, 0, 1,  1, 0, 0, 1);  // 14: force_on held
    add(17, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // 15: unit not ready
    add(1,  0, 0, 0, 1, 0,  1, 1, 0, 0);  // 16: immediate ack
    add(5,  0, 0, 0, 0, 0,  0, 0, 1, 0);  // 17: gated
    add(17, 0, 0, 0, 0, 1,  1, 0, 0, 1);  // 18: after reset
    add(1,  0, 0, 0, 1, 1,  1, 1, 0, 0);  // 19
    add(40, 0, 0, 0, 0, 1,  0, 0, 1, 0);  // 20: 40 gated cycles

    rst = 1'b1; busy = 0; frc = 0; valid = 0; ack = 0; uready = 1;
    #2;
    chk("reset cg_en", 32'(cg_en), 32'd1);
    chk("reset sleep_req", 32'(sreq), 32'd0);
    chk("reset gated", 32'(gated), 32'd0);
    chk("reset req_ready", 32'(ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_vecs(0, 17);

    // Asynchronous reset in the middle of a gated period.
    uready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst cg_en", 32'(cg_en), 32'd1);
    chk("async rst sleep_req", 32'(sreq), 32'd0);
    chk("async rst gated", 32'(gated), 32'd0);
    chk("async rst ready=unit_ready 0", 32'(ready), 32'd0);
    uready = 1'b1;
    #1;
    chk("async rst ready=unit_ready 1", 32'(ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    chk("stats cleared by reset", gcycles, 32'd0);
`endif

    run_vecs(18, 20);

    // Wake from a 40-cycle gated period.
    valid = 1'b1;
    @(negedge clk);
    chk("stats gated still", 32'(gated), 32'd1);
`ifdef CLOCK_GATE_CTRL_STATS_EN
    chk("stats gated_cycles", gcycles, 32'd40);
`endif
    @(posedge clk);
    #1;
    chk("wake cg_en N+1", 32'(cg_en), 32'd1);
    chk("wake ready N+1", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("wake ready N+2", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("wake ready N+3", 32'(ready), 32'd1);
    valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
